key_debounce_array: RTL and testbench

- Parametrised multi-channel push-button conditioner. Successor to the single-key 8-sample debouncer.
- Per channel: input synchroniser, N-sample agreement filter and debounced level output.
- Also produces one-cycle press/release pulses and an optional hold-to-auto-repeat pulse.
- Sits between raw board buttons and game control logic (fire, move, menu), clocked from the 1 ms tick clock.

---
 rtl/key_pkg.sv | 28 ++
 rtl/key_debounce_channel.sv | 140 ++++++++++++++
 rtl/key_debounce_array.sv | 68 ++++++
 tb/tb_key_debounce_array.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// ============================================================================
// key_pkg : shared types and defaults for the key debounce array
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } key_state_e;

  localparam int KEY_SHIFT_LEN     = 8;
  localparam int KEY_HOLD_CYCLES   = 500;
  localparam int KEY_REPEAT_CYCLES = 100;

  // Counter only ever holds values up to max(hold, repeat) - 1.
  function automatic int key_cnt_width(input int hold_cycles, input int repeat_cycles);
    int m;
    m = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// ============================================================================
// key_debounce_channel : synchroniser, N-sample filter, edge pulses, auto-repeat
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module key_debounce_channel
  import key_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int SHIFT_LEN     = KEY_SHIFT_LEN,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = KEY_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES
) (
  input  logic clk_1ms,
  input  logic rst_n,
  input  logic push,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic press_next
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SHIFT_LEN-1:0]   sh_q, sh_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], push};
    sh_d   = {sh_q[SHIFT_LEN-2:0], sync_q[SYNC_STAGES-1]};
    // Level only moves on unanimous history; mixed history holds it.
    if (&sh_d) begin
      level_d = 1'b1;
    end else if (~|sh_d) begin
      level_d = 1'b0;
    end else begin
      level_d = level_q;
    end
    rise      = level_d & ~level_q;
    fall      = ~level_d & level_q;
    press_d   = rise;
    release_d = fall;
  end

  always_ff @(posedge clk_1ms) begin
    if (!rst_n) begin
      sync_q    <= '0;
      sh_q      <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      sh_q      <= sh_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_next    = press_d;

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      localparam int CW = key_cnt_width(HOLD_CYCLES, REPEAT_CYCLES);
      localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
      localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

      key_state_e      state_q, state_d;
      logic [CW-1:0]   cnt_q, cnt_d;
      logic            rep_q, rep_d;

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = 1'b0;
        case (state_q)
          IDLE: begin
            cnt_d = '0;
            if (rise) state_d = HOLD;
          end
          HOLD: begin
            if (cnt_q == HOLD_LAST) begin
              state_d = REPEAT;
              cnt_d   = '0;
              rep_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          REPEAT: begin
            if (cnt_q == REPEAT_LAST) begin
              cnt_d = '0;
              rep_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
        // Release wins over a repeat landing on the same edge.
        if (fall) begin
          state_d = IDLE;
          cnt_d   = '0;
          rep_d   = 1'b0;
        end
      end

      always_ff @(posedge clk_1ms) begin
        if (!rst_n) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          rep_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          rep_q   <= rep_d;
        end
      end

      assign repeat_pulse = rep_q;
    end else begin : g_no_repeat
      assign repeat_pulse = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/key_debounce_array.sv
// ============================================================================
// key_debounce_array : multi-channel push-button conditioner
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module key_debounce_array
  import key_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int SHIFT_LEN     = KEY_SHIFT_LEN,
  parameter int REPEAT_EN     = 1,
  parameter int HOLD_CYCLES   = KEY_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES
) (
  input  logic                clk_1ms,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] push,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  logic [CHANNELS-1:0] press_next;
  logic                any_press_q, any_press_d;

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      key_debounce_channel #(
        .SYNC_STAGES  (SYNC_STAGES),
        .SHIFT_LEN    (SHIFT_LEN),
        .REPEAT_EN    (REPEAT_EN),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_ch (
        .clk_1ms      (clk_1ms),
        .rst_n        (rst_n),
        .push         (push[i]),
        .level_out    (level_out[i]),
        .press_pulse  (press_pulse[i]),
        .release_pulse(release_pulse[i]),
        .repeat_pulse (repeat_pulse[i]),
        .press_next   (press_next[i])
      );
    end
  endgenerate

  // Registered from the pulses' next-state so it lines up with press_pulse.
  always_comb begin
    any_press_d = |press_next;
  end

  always_ff @(posedge clk_1ms) begin
    if (!rst_n) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce_array.sv
// ============================================================================
// tb_key_debounce_array : table, directed and random checks of key_debounce_array
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_key_debounce_array;

  localparam int NCH   = 4;
  localparam int SYNC  = 2;
  localparam int SHIFT = 8;
  localparam int HOLD  = 20;
  localparam int REP   = 5;

  logic           clk_1ms = 1'b0;
  logic           rst_n   = 1'b0;
  logic [NCH-1:0] push    = '0;

  logic [NCH-1:0] level_out, press_pulse, release_pulse, repeat_pulse;
  logic           any_press;
  logic [NCH-1:0] level_out2, press_pulse2, release_pulse2, repeat_pulse2;
  logic           any_press2;

  always #5 clk_1ms = ~clk_1ms;

  key_debounce_array #(
    .CHANNELS(NCH), .SYNC_STAGES(SYNC), .SHIFT_LEN(SHIFT),
    .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk_1ms(clk_1ms), .rst_n(rst_n), .push(push),
    .level_out(level_out), .press_pulse(press_pulse),
    .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
    .any_press(any_press)
  );

  key_debounce_array #(
    .CHANNELS(NCH), .SYNC_STAGES(SYNC), .SHIFT_LEN(SHIFT),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut_norep (
    .clk_1ms(clk_1ms), .rst_n(rst_n), .push(push),
    .level_out(level_out2), .press_pulse(press_pulse2),
    .release_pulse(release_pulse2), .repeat_pulse(repeat_pulse2),
    .any_press(any_press2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run-length of identical synchronised samples decides the level;
  // repeats fall at fixed distances from the press.
  logic [NCH-1:0] m_pipe [SYNC];
  int             m_run  [NCH];
  logic           m_val  [NCH];
  int             m_held [NCH];
  logic [NCH-1:0] m_lvl;
  logic [NCH-1:0] e_prs, e_rel, e_rep;
  logic           e_any;

  task automatic model_edge(input logic rn, input logic [NCH-1:0] p);
    logic [NCH-1:0] s, nl;
    e_prs = '0; e_rel = '0; e_rep = '0;
    if (!rn) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = '0;
      for (int c = 0; c < NCH; c++) begin
        m_run[c] = SHIFT; m_val[c] = 1'b0; m_held[c] = 0;
      end
      m_lvl = '0;
      e_any = 1'b0;
      return;
    end
    s = m_pipe[SYNC-1];
    for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = p;
    for (int c = 0; c < NCH; c++) begin
      if (s[c] == m_val[c]) begin
        if (m_run[c] < SHIFT) m_run[c]++;
      end else begin
        m_val[c] = s[c];
        m_run[c] = 1;
      end
      nl[c] = (m_run[c] >= SHIFT) ? m_val[c] : m_lvl[c];
      if (nl[c] && !m_lvl[c]) begin
        e_prs[c] = 1'b1; m_held[c] = 0;
      end else if (!nl[c] && m_lvl[c]) begin
        e_rel[c] = 1'b1; m_held[c] = 0;
      end else if (nl[c]) begin
        m_held[c]++;
        if (m_held[c] >= HOLD && ((m_held[c] - HOLD) % REP) == 0) e_rep[c] = 1'b1;
      end
    end
    m_lvl = nl;
    e_any = |e_prs;
  endtask

  task automatic step(input logic rn, input logic [NCH-1:0] p);
    rst_n = rn;
    push  = p;
    @(posedge clk_1ms);
    model_edge(rn, p);
    #1;
    check("model_rep", {15'd0, level_out, press_pulse, release_pulse, repeat_pulse, any_press},
                       {15'd0, m_lvl, e_prs, e_rel, e_rep, e_any});
    check("model_norep", {15'd0, level_out2, press_pulse2, release_pulse2, repeat_pulse2, any_press2},
                         {15'd0, m_lvl, e_prs, e_rel, 4'd0, e_any});
  endtask

  typedef struct {
    logic           rn;
    logic [NCH-1:0] p;
    logic [NCH-1:0] lvl;
    logic [NCH-1:0] prs;
    logic           any;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int cnt, first, found;
    logic [NCH-1:0] pstate, gl;
    logic pat [8];
    logic norep_seen;

    // Reset with keys held, release, first debounced press at the 10th edge.
    for (int i = 0; i < 15; i++) begin
      tbl[i].rn  = (i >= 3);
      tbl[i].p   = 4'hF;
      tbl[i].lvl = (i >= 12) ? 4'hF : 4'h0;
      tbl[i].prs = (i == 12) ? 4'hF : 4'h0;
      tbl[i].any = (i == 12);
    end
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rn, tbl[i].p);
      check("tbl_level", {28'd0, level_out}, {28'd0, tbl[i].lvl});
      check("tbl_press", {28'd0, press_pulse}, {28'd0, tbl[i].prs});
      check("tbl_any", {31'd0, any_press}, {31'd0, tbl[i].any});
      check("tbl_quiet", {24'd0, release_pulse, repeat_pulse}, 32'd0);
    end

    for (int i = 0; i < 14; i++) step(1'b1, 4'h0);

    // Bounce rejection on channel 0.
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(1'b1, {3'b000, pat[k % 8]});
      if (level_out[0] || press_pulse[0] || release_pulse[0]) cnt++;
    end
    check("bounce_quiet", cnt, 0);
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 4'b0001);
      if (press_pulse[0]) cnt++;
    end
    check("bounce_single_press", cnt, 1);
    for (int i = 0; i < 14; i++) step(1'b1, 4'h0);

    // Release latency on channel 2.
    for (int i = 0; i < 22; i++) step(1'b1, 4'b0100);
    check("rel_pressed", {31'd0, level_out[2]}, 32'd1);
    found = 0;
    for (int j = 1; j <= 20 && found == 0; j++) begin
      step(1'b1, 4'h0);
      if (release_pulse[2]) found = j;
    end
    check("rel_latency", found, 10);
    check("rel_level", {31'd0, level_out[2]}, 32'd0);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      step(1'b1, 4'h0);
      if (repeat_pulse[2] || release_pulse[2]) cnt++;
    end
    check("rel_no_repeat", cnt, 0);

    // Auto-repeat on channel 1.
    found = 0;
    for (int j = 0; j < 20 && found == 0; j++) begin
      step(1'b1, 4'b0010);
      if (press_pulse[1]) found = 1;
    end
    check("rep_press_seen", found, 1);
    first = 0; cnt = 0;
    for (int j = 1; j <= 45; j++) begin
      step(1'b1, 4'b0010);
      if (repeat_pulse[1] && first == 0) first = j;
      if (repeat_pulse[1] && j > 20) cnt++;
    end
    check("rep_first_delay", first, HOLD);
    check("rep_count_25", cnt, 5);
    found = 0;
    for (int j = 0; j < 20 && found == 0; j++) begin
      step(1'b1, 4'h0);
      if (release_pulse[1]) begin
        found = 1;
        check("rep_release_no_rep", {31'd0, repeat_pulse[1]}, 32'd0);
      end
    end
    check("rep_release_seen", found, 1);
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 4'h0);
      if (repeat_pulse[1]) cnt++;
    end
    check("rep_stopped", cnt, 0);

    // Reset while channel 3 is repeating.
    for (int j = 0; j < 40; j++) step(1'b1, 4'b1000);
    step(1'b0, 4'b1000);
    check("midrst_outputs",
          {15'd0, level_out, press_pulse, release_pulse, repeat_pulse, any_press}, 32'd0);
    found = 0;
    for (int j = 1; j <= 20 && found == 0; j++) begin
      step(1'b1, 4'b1000);
      if (press_pulse[3]) found = j;
    end
    check("midrst_fresh_press", found, SHIFT + SYNC);

    // Long hold on the no-repeat build.
    norep_seen = 1'b0;
    for (int j = 0; j < 200; j++) begin
      step(1'b1, 4'b1001);
      if (repeat_pulse2 != 4'h0) norep_seen = 1'b1;
    end
    check("norep_quiet", {31'd0, norep_seen}, 32'd0);
    check("norep_level", {28'd0, level_out2}, 32'h9);

    // Random key activity with glitches and occasional reset.
    pstate = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) pstate[c] = ~pstate[c];
        gl[c] = ($urandom_range(0, 9) == 0);
      end
      step(($urandom_range(0, 999) != 0), pstate ^ gl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
